// File: rtl/adc_emu_pkg.sv
// Shared definitions for the ADC pulse emulator: sample width, FSM encoding,
// LFSR constants and the saturating sample adder also used by the trigger bench.
package adc_emu_pkg;

  localparam int ADC_W  = 14;
  localparam int CALC_W = ADC_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RISE  = 2'd2,
    DECAY = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic signed [CALC_W:0] ADC_MAX = (CALC_W+1)'((1 << ADC_W) - 1);

  // Signed add clamped to the unsigned ADC range [0, 2^ADC_W-1]; one guard bit
  // keeps the sum itself from wrapping before the clamp.
  function automatic logic [ADC_W-1:0] sat_add(input logic signed [CALC_W-1:0] a,
                                               input logic signed [CALC_W-1:0] b);
    logic signed [CALC_W:0] sum;
    sum = $signed({a[CALC_W-1], a}) + $signed({b[CALC_W-1], b});
    if (sum[CALC_W]) begin
      return '0;
    end else if (sum > ADC_MAX) begin
      return '1;
    end else begin
      return sum[ADC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR noise source; holds its value while disabled and
// reloads the package seed on reset.
module lfsr16
  import adc_emu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = ^(r_lfsr & LFSR_TAPS);
  assign o_state    = r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], w_feedback};
    end
  end

endmodule

// File: rtl/adc_pulse_emulator.sv
// Synthetic ADC sample source: noisy baseline with periodic or forced pulses
// (linear rise, exponential decay) for self-test of the trigger and readout path.
module adc_pulse_emulator
  import adc_emu_pkg::*;
#(
  parameter int BASELINE   = 8054,
  parameter int PERIOD     = 4000,
  parameter int NOISE_BITS = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             forceFire,
  input  logic [ADC_W-1:0] pulseAmp,
  input  logic [ADC_W-1:0] riseStep,
  input  logic [3:0]       decayShift,
  output logic [ADC_W-1:0] ADC_OUT,
  output logic             pulseStart,
  output logic             busy,
  output logic [ADC_W-1:0] pulseCount,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [15:0] NOISE_MASK = 16'((1 << NOISE_BITS) - 1);
  localparam logic [CALC_W-1:0] NOISE_HALF = (NOISE_BITS == 0) ? '0 : CALC_W'(1 << (NOISE_BITS - 1));

  state_t           r_state;
  state_t           w_state_next;
  logic [ADC_W-1:0] r_offset;
  logic [ADC_W-1:0] w_offset_next;
  logic [CNT_W-1:0] r_period_cnt;
  logic [ADC_W-1:0] r_adc_out;
  logic             r_pulse_start;
  logic [ADC_W-1:0] r_pulse_count;
  logic             w_fire;

  logic [ADC_W-1:0] w_step;
  logic [ADC_W:0]   w_rise_sum;
  logic [ADC_W-1:0] w_rise_val;
  logic [ADC_W-1:0] w_dec_shift;
  logic [ADC_W-1:0] w_dec_amt;
  logic [ADC_W-1:0] w_dec_val;

  logic [15:0]              w_lfsr;
  logic signed [CALC_W-1:0] w_noise;
  logic signed [CALC_W-1:0] w_level;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (enable),
    .o_state (w_lfsr)
  );

  // Shaping arithmetic; a lowered pulseAmp mid-rise lands on the new peak.
  assign w_step      = (riseStep == '0) ? ADC_W'(1) : riseStep;
  assign w_rise_sum  = {1'b0, r_offset} + {1'b0, w_step};
  assign w_rise_val  = (w_rise_sum >= {1'b0, pulseAmp}) ? pulseAmp : w_rise_sum[ADC_W-1:0];
  assign w_dec_shift = r_offset >> decayShift;
  assign w_dec_amt   = (w_dec_shift == '0) ? ADC_W'(1) : w_dec_shift;
  assign w_dec_val   = (r_offset <= w_dec_amt) ? '0 : (r_offset - w_dec_amt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_offset_next = r_offset;
    w_fire        = 1'b0;
    if (!enable) begin
      w_state_next  = IDLE;
      w_offset_next = '0;
    end else begin
      case (r_state)
        IDLE: w_state_next = WAIT;
        WAIT: begin
          if (r_period_cnt == CNT_LAST || forceFire) begin
            w_state_next = RISE;
            w_fire       = 1'b1;
          end
        end
        RISE: begin
          w_offset_next = w_rise_val;
          if (w_rise_val == pulseAmp) w_state_next = DECAY;
        end
        DECAY: begin
          w_offset_next = w_dec_val;
          if (w_dec_val == '0) w_state_next = WAIT;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state == RISE) || (r_state == DECAY);
    o_dbg_state = r_state;
  end

  // Period counter saturates so an expiry during a busy pulse fires on WAIT entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period_cnt <= '0;
    end else if (!enable || r_state == IDLE || w_fire) begin
      r_period_cnt <= '0;
    end else if (r_period_cnt != CNT_LAST) begin
      r_period_cnt <= r_period_cnt + CNT_W'(1);
    end
  end

  assign w_noise = $signed(CALC_W'(w_lfsr & NOISE_MASK) - NOISE_HALF);
  assign w_level = $signed(CALC_W'(BASELINE) + CALC_W'(r_offset));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_offset      <= '0;
      r_adc_out     <= ADC_W'(BASELINE);
      r_pulse_start <= 1'b0;
      r_pulse_count <= '0;
    end else begin
      r_offset      <= w_offset_next;
      r_adc_out     <= enable ? sat_add(w_level, w_noise) : ADC_W'(BASELINE);
      r_pulse_start <= w_fire;
      if (w_fire) r_pulse_count <= r_pulse_count + ADC_W'(1);
    end
  end

  assign ADC_OUT    = r_adc_out;
  assign pulseStart = r_pulse_start;
  assign pulseCount = r_pulse_count;

endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Directed bench for adc_pulse_emulator: main instance without noise, plus a
// high-baseline and a low-baseline noisy instance for the output clamps.
module tb_adc_pulse_emulator;
  import adc_emu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, enable, force_fire;
  logic [ADC_W-1:0] pulse_amp, rise_step;
  logic [3:0]       decay_shift;
  logic [ADC_W-1:0] adc_out, pulse_count;
  logic             pulse_start, busy;
  logic [1:0]       dbg_state;

  logic             en_x, ff_x;
  logic [ADC_W-1:0] hi_amp, hi_step, lo_amp, lo_step;
  logic [3:0]       x_shift;
  logic [ADC_W-1:0] hi_adc, hi_pc, lo_adc, lo_pc;
  logic             hi_ps, hi_busy, lo_ps, lo_busy;
  logic [1:0]       hi_st, lo_st;

  adc_pulse_emulator #(.BASELINE(8054), .PERIOD(50), .NOISE_BITS(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .forceFire(force_fire),
    .pulseAmp(pulse_amp), .riseStep(rise_step), .decayShift(decay_shift),
    .ADC_OUT(adc_out), .pulseStart(pulse_start), .busy(busy),
    .pulseCount(pulse_count), .o_dbg_state(dbg_state)
  );

  adc_pulse_emulator #(.BASELINE(16000), .PERIOD(50), .NOISE_BITS(0)) dut_hi (
    .clk(clk), .reset_n(reset_n), .enable(en_x), .forceFire(ff_x),
    .pulseAmp(hi_amp), .riseStep(hi_step), .decayShift(x_shift),
    .ADC_OUT(hi_adc), .pulseStart(hi_ps), .busy(hi_busy),
    .pulseCount(hi_pc), .o_dbg_state(hi_st)
  );

  adc_pulse_emulator #(.BASELINE(5), .PERIOD(50), .NOISE_BITS(5)) dut_lo (
    .clk(clk), .reset_n(reset_n), .enable(en_x), .forceFire(ff_x),
    .pulseAmp(lo_amp), .riseStep(lo_step), .decayShift(x_shift),
    .ADC_OUT(lo_adc), .pulseStart(lo_ps), .busy(lo_busy),
    .pulseCount(lo_pc), .o_dbg_state(lo_st)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string tag, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pulse_start && n < limit);
    chk(tag, 32'(pulse_start), 32'd1);
  endtask

  // Monitors sampled on the falling edge: clamp extremes and a simple
  // rising-slope threshold trigger at 9400 on the main instance.
  int hi_min = 99999, hi_max = 0, lo_min = 99999, lo_bad = 0;
  int trig_cnt = 0;
  logic trig_on = 1'b0;
  int prev_adc = 8054;

  always @(negedge clk) begin
    if (reset_n) begin
      if (int'(hi_adc) < hi_min) hi_min = int'(hi_adc);
      if (int'(hi_adc) > hi_max) hi_max = int'(hi_adc);
      if (int'(lo_adc) < lo_min) lo_min = int'(lo_adc);
      if (int'(lo_adc) > 120) lo_bad++;
      if (trig_on && prev_adc < 9400 && int'(adc_out) >= 9400) trig_cnt++;
      prev_adc = int'(adc_out);
    end
  end

  int ramp_exp[8] = '{8054, 9054, 10054, 11054, 10304, 9742, 9320, 9004};
  int lo_exp[5]   = '{0, 0, 0, 4, 19};
  int lo_seen[5];

  initial begin
    int n, bad, extra, pulses, cyc;
    logic [ADC_W-1:0] pc0;

    reset_n = 1'b0; enable = 1'b0; force_fire = 1'b0;
    pulse_amp = '0; rise_step = '0; decay_shift = '0;
    en_x = 1'b1; ff_x = 1'b0; x_shift = 4'd2;
    hi_amp = 14'd2000; hi_step = 14'd1000; lo_amp = 14'd100; lo_step = 14'd50;
    repeat (3) tick();
    chk("rst_adc", 32'(adc_out), 32'd8054);
    chk("rst_pulse_start", 32'(pulse_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulse_count", 32'(pulse_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_hi_adc", 32'(hi_adc), 32'd16000);
    reset_n = 1'b1;

    // Disabled: baseline held, no strobes; noisy low-baseline instance clamps at 0.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (adc_out !== 14'd8054 || pulse_start !== 1'b0 || dbg_state !== 2'(IDLE)) bad++;
      if (i < 5) lo_seen[i] = int'(lo_adc);
    end
    chk("idle_hold", 32'(bad), 32'd0);
    for (int i = 0; i < 5; i++) chk($sformatf("lo_noise%0d", i), 32'(lo_seen[i]), 32'(lo_exp[i]));

    // Periodic pulses
    pulse_amp = 14'd3000; rise_step = 14'd1000; decay_shift = 4'd2; enable = 1'b1;
    wait_pulse("p1_seen", 200, n);
    chk("p1_latency", 32'(n), 32'd51);
    chk("p1_busy", 32'(busy), 32'd1);
    chk("p1_state", 32'(dbg_state), 32'(RISE));
    chk("p1_count", 32'(pulse_count), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ramp%0d", i), 32'(adc_out), 32'(ramp_exp[i]));
    end
    repeat (37) tick();
    chk("tail_adc", 32'(adc_out), 32'd8054);
    chk("tail_busy", 32'(busy), 32'd0);
    chk("tail_state", 32'(dbg_state), 32'(WAIT));
    wait_pulse("p2_seen", 100, n);
    chk("p2_gap", 32'(n), 32'd5);
    wait_pulse("p3_seen", 100, n);
    chk("p3_gap", 32'(n), 32'd50);
    chk("p3_count", 32'(pulse_count), 32'd3);

    // Forced pulse in WAIT, ignored force in DECAY
    repeat (45) tick();
    force_fire = 1'b1;
    tick();
    force_fire = 1'b0;
    chk("force_strobe", 32'(pulse_start), 32'd1);
    chk("force_count", 32'(pulse_count), 32'd4);
    repeat (4) tick();
    chk("force_decay_state", 32'(dbg_state), 32'(DECAY));
    force_fire = 1'b1;
    repeat (3) tick();
    force_fire = 1'b0;
    extra = 0;
    for (int i = 0; i < 38; i++) begin
      tick();
      if (pulse_start) extra++;
    end
    chk("force_ignored", 32'(extra), 32'd0);
    chk("force_ignored_count", 32'(pulse_count), 32'd4);

    // Enable dropped mid-rise, then re-enabled
    wait_pulse("p5_seen", 100, n);
    chk("p5_gap", 32'(n), 32'd5);
    tick();
    chk("midrise_state", 32'(dbg_state), 32'(RISE));
    enable = 1'b0;
    tick();
    chk("drop_state", 32'(dbg_state), 32'(IDLE));
    chk("drop_adc", 32'(adc_out), 32'd8054);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_count", 32'(pulse_count), 32'd5);
    enable = 1'b1;
    tick();
    chk("reen_state", 32'(dbg_state), 32'(WAIT));
    wait_pulse("p6_seen", 100, n);
    chk("reen_latency", 32'(n), 32'd50);

    // Zero amplitude: one RISE clock, one DECAY clock, still counted
    repeat (45) tick();
    pulse_amp = '0;
    force_fire = 1'b1;
    tick();
    force_fire = 1'b0;
    chk("amp0_strobe", 32'(pulse_start), 32'd1);
    chk("amp0_count", 32'(pulse_count), 32'd7);
    tick();
    chk("amp0_decay", 32'(dbg_state), 32'(DECAY));
    chk("amp0_adc1", 32'(adc_out), 32'd8054);
    tick();
    chk("amp0_wait", 32'(dbg_state), 32'(WAIT));
    chk("amp0_busy", 32'(busy), 32'd0);
    chk("amp0_adc2", 32'(adc_out), 32'd8054);

    // riseStep of zero advances by one per clock
    pulse_amp = 14'd3; rise_step = '0;
    force_fire = 1'b1;
    tick();
    force_fire = 1'b0;
    chk("step0_count", 32'(pulse_count), 32'd8);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("step0_adc%0d", i), 32'(adc_out), 32'(8055 + i));
    end

    // Trigger loop-back: one threshold crossing per pulse over 20 pulses
    pulse_amp = 14'd3000; rise_step = 14'd1000;
    repeat (20) tick();
    pc0 = pulse_count;
    trig_cnt = 0;
    trig_on = 1'b1;
    pulses = 0;
    cyc = 0;
    while (pulses < 20 && cyc < 1500) begin
      tick();
      cyc++;
      if (pulse_start) pulses++;
    end
    repeat (10) tick();
    trig_on = 1'b0;
    chk("trig_pulses", 32'(pulses), 32'd20);
    chk("trig_count", 32'(trig_cnt), 32'd20);
    chk("trig_pc_delta", 32'(ADC_W'(pulse_count - pc0)), 32'd20);

    // Reset mid-pulse
    wait_pulse("pr_seen", 100, n);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_adc", 32'(adc_out), 32'd8054);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(pulse_count), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    chk("arst_strobe", 32'(pulse_start), 32'd0);
    tick();
    reset_n = 1'b1;

    chk("hi_clamp_max", 32'(hi_max), 32'd16383);
    chk("hi_min", 32'(hi_min), 32'd16000);
    chk("lo_clamp_min", 32'(lo_min), 32'd0);
    chk("lo_no_wrap", 32'(lo_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
